load_store_unit: RTL

Initiator-side companion to the word-addressed data memory of the 32-bit MIPS. It takes byte, halfword and word load/store requests from the core, translates byte addresses into word-index memory accesses, and performs read-modify-write for sub-word stores, because the memory only writes whole words. It sign- or zero-extends load data and stalls the core until each access completes.

---
 rtl/load_store_unit.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: initiator-side bridge between the MIPS core and a
// word-addressed data memory. Translates byte addresses into word indices,
// performs read-modify-write for sub-word stores and extends load data.
//
// Build option: define LOADSTORE_SUBWORD_EN to enable byte/halfword accesses,
// sign/zero extension and read-modify-write. Without it only aligned word
// accesses are legal and everything else completes as misaligned.
module load_store_unit #(
  parameter int WIDTH = 32
) (
  input  logic             LoadStore_CLK,
  input  logic             LoadStore_RST,
  input  logic             LoadStore_Req,
  input  logic             LoadStore_We,
  input  logic [1:0]       LoadStore_Size,
  input  logic             LoadStore_Unsigned,
  input  logic [WIDTH-1:0] LoadStore_Addr,
  input  logic [WIDTH-1:0] LoadStore_WD,
  output logic [WIDTH-1:0] LoadStore_RD,
  output logic             LoadStore_Done,
  output logic             LoadStore_Stall,
  output logic             LoadStore_Misaligned,
  output logic [WIDTH-1:0] LoadStore_MemA,
  output logic [WIDTH-1:0] LoadStore_MemWD,
  output logic             LoadStore_MemWE,
  input  logic [WIDTH-1:0] LoadStore_MemRD
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-3:0] word_addr_r;
  logic [WIDTH-1:0] wd_r;
  logic [WIDTH-1:0] rd_r;
  logic             we_r;
  logic             mis_r;
  logic             mis_s;
  logic [WIDTH-1:0] merged_s;

`ifdef LOADSTORE_SUBWORD_EN
  logic [1:0]       size_r;
  logic [1:0]       off_r;
  logic             uns_r;
  logic [WIDTH-1:0] word_r;

  // Select the addressed lane(s) of a memory word and sign/zero extend them.
  function automatic logic [WIDTH-1:0] load_extend(
    input logic [WIDTH-1:0] word,
    input logic [1:0]       size,
    input logic [1:0]       off,
    input logic             uns
  );
    logic [WIDTH-1:0] sh;
    logic [7:0]       b;
    logic [15:0]      h;
    sh = word >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   load_extend = {{(WIDTH-8){b[7] & ~uns}}, b};
      2'b01:   load_extend = {{(WIDTH-16){h[15] & ~uns}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Replace the addressed lane(s) of the captured word with right-aligned store data.
  function automatic logic [WIDTH-1:0] store_merge(
    input logic [WIDTH-1:0] word,
    input logic [WIDTH-1:0] wd,
    input logic [1:0]       size,
    input logic [1:0]       off
  );
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] data;
    case (size)
      2'b00: begin
        mask = {{(WIDTH-8){1'b0}}, 8'hFF} << {off, 3'b000};
        data = {{(WIDTH-8){1'b0}}, wd[7:0]} << {off, 3'b000};
      end
      2'b01: begin
        mask = {{(WIDTH-16){1'b0}}, 16'hFFFF} << {off[1], 4'b0000};
        data = {{(WIDTH-16){1'b0}}, wd[15:0]} << {off[1], 4'b0000};
      end
      default: begin
        mask = {WIDTH{1'b1}};
        data = wd;
      end
    endcase
    store_merge = (word & ~mask) | (data & mask);
  endfunction

  // Alignment check of the incoming request (sub-word sizes legal).
  always_comb begin
    mis_s = 1'b0;
    case (LoadStore_Size)
      2'b00:   mis_s = 1'b0;
      2'b01:   mis_s = LoadStore_Addr[0];
      2'b10:   mis_s = |LoadStore_Addr[1:0];
      default: mis_s = 1'b1;
    endcase
  end

  // Write data: whole word passes through, sub-word stores are merged.
  always_comb begin
    merged_s = wd_r;
    if (size_r == 2'b10) begin
      merged_s = wd_r;
    end else begin
      merged_s = store_merge(word_r, wd_r, size_r, off_r);
    end
  end

  // Sub-word request fields and the word captured during READ.
  always_ff @(posedge LoadStore_CLK or negedge LoadStore_RST) begin
    if (!LoadStore_RST) begin
      size_r <= 2'b00;
      off_r  <= 2'b00;
      uns_r  <= 1'b0;
      word_r <= {WIDTH{1'b0}};
    end else if (state_r == IDLE && LoadStore_Req) begin
      size_r <= LoadStore_Size;
      off_r  <= LoadStore_Addr[1:0];
      uns_r  <= LoadStore_Unsigned;
    end else if (state_r == READ) begin
      word_r <= LoadStore_MemRD;
    end
  end
`else
  // Alignment check of the incoming request (only aligned words legal).
  always_comb begin
    mis_s = (LoadStore_Size != 2'b10) | (|LoadStore_Addr[1:0]);
  end

  // Write data is always a whole word.
  always_comb begin
    merged_s = wd_r;
  end
`endif

  // State register.
  always_ff @(posedge LoadStore_CLK or negedge LoadStore_RST) begin
    if (!LoadStore_RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!LoadStore_Req) begin
          next_state_s = IDLE;
        end else if (mis_s) begin
          next_state_s = RESP;
        end else if (!LoadStore_We) begin
          next_state_s = READ;
`ifdef LOADSTORE_SUBWORD_EN
        end else if (LoadStore_Size != 2'b10) begin
          next_state_s = READ;
`endif
        end else begin
          next_state_s = WRITE;
        end
      end
      READ: begin
        if (we_r) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = RESP;
        end
      end
      WRITE:   next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Common request fields latched at acceptance; load result captured on READ->RESP.
  always_ff @(posedge LoadStore_CLK or negedge LoadStore_RST) begin
    if (!LoadStore_RST) begin
      word_addr_r <= {(WIDTH-2){1'b0}};
      wd_r        <= {WIDTH{1'b0}};
      we_r        <= 1'b0;
      mis_r       <= 1'b0;
      rd_r        <= {WIDTH{1'b0}};
    end else if (state_r == IDLE && LoadStore_Req) begin
      word_addr_r <= LoadStore_Addr[WIDTH-1:2];
      wd_r        <= LoadStore_WD;
      we_r        <= LoadStore_We;
      mis_r       <= mis_s;
    end else if (state_r == READ && !we_r) begin
`ifdef LOADSTORE_SUBWORD_EN
      rd_r <= load_extend(LoadStore_MemRD, size_r, off_r, uns_r);
`else
      rd_r <= LoadStore_MemRD;
`endif
    end
  end

  // Output decode from state and latched request; memory bus idles at zero.
  always_comb begin
    LoadStore_Done       = 1'b0;
    LoadStore_Stall      = 1'b0;
    LoadStore_Misaligned = 1'b0;
    LoadStore_MemA       = {WIDTH{1'b0}};
    LoadStore_MemWD      = {WIDTH{1'b0}};
    LoadStore_MemWE      = 1'b0;
    case (state_r)
      IDLE: begin
        LoadStore_Stall = LoadStore_Req;
      end
      READ: begin
        LoadStore_Stall = 1'b1;
        LoadStore_MemA  = {2'b00, word_addr_r};
      end
      WRITE: begin
        LoadStore_Stall = 1'b1;
        LoadStore_MemA  = {2'b00, word_addr_r};
        LoadStore_MemWD = merged_s;
        LoadStore_MemWE = 1'b1;
      end
      RESP: begin
        LoadStore_Done       = 1'b1;
        LoadStore_Misaligned = mis_r;
      end
      default: begin
        LoadStore_Stall = 1'b0;
      end
    endcase
  end

  assign LoadStore_RD = rd_r;

endmodule
